// File: rtl/axi_lite_ram_slave_pkg.sv
// Shared widths, response codes, FSM encodings and address decode for the AXI-lite RAM slave.
package axi_lite_ram_slave_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_MEM,  W_RESP} w_state_e;

  // An address is out of range when it lies below the window base, or when its
  // word offset from the base reaches the memory depth.
  function automatic logic addr_is_err(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input int unsigned       depth);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr < base) || ((off >> 3) >= depth);
  endfunction

endpackage

// File: rtl/axi_lite_ram_slave_array.sv
// Byte-writable word storage: one combinational read port, one byte-enabled write port, no reset.
module axi_ram_array
  import axi_lite_ram_slave_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [STRB_W-1:0] wr_be_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // The read sees the value before any write landing on the same edge.
  assign rd_data_o = mem_q[rd_idx_i];

  // Only the enabled byte lanes of the addressed word are updated.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI-lite slave fronting a word RAM: read FSM with fixed latency, write FSM joining AW and W.
module axi_lite_ram_slave
  import axi_lite_ram_slave_pkg::*;
#(
  parameter int                DEPTH     = 1024,
  parameter int                RD_LAT    = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  r_state_e          r_state_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [3:0]        lat_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  w_state_e          w_state_q;
  logic              aw_got_q, w_got_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        bresp_q;

  logic              ar_err, aw_err, aw_hs, w_hs, ram_we;
  logic [IDX_W-1:0]  ar_idx, aw_idx;
  logic [DATA_W-1:0] ram_rd_data;

  assign ar_err = addr_is_err(ar_addr_q, BASE_ADDR, DEPTH);
  assign aw_err = addr_is_err(aw_addr_q, BASE_ADDR, DEPTH);
  assign ar_idx = IDX_W'((ar_addr_q - BASE_ADDR) >> 3);
  assign aw_idx = IDX_W'((aw_addr_q - BASE_ADDR) >> 3);

  // Readies are gated by rst so they drop immediately in reset and rise with its release.
  assign arready = rst && (r_state_q == R_IDLE);
  assign awready = rst && (w_state_q == W_IDLE) && !aw_got_q;
  assign wready  = rst && (w_state_q == W_IDLE) && !w_got_q;
  assign rvalid  = (r_state_q == R_RESP);
  assign bvalid  = (w_state_q == W_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bresp   = bresp_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  // A write whose W_MEM cycle meets reset, or that targets a bad address, never reaches the array.
  assign ram_we = rst && (w_state_q == W_MEM) && !aw_err;

  axi_ram_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk_i     (clk),
    .rd_idx_i  (ar_idx),
    .rd_data_o (ram_rd_data),
    .we_i      (ram_we),
    .wr_idx_i  (aw_idx),
    .wr_be_i   (wstrb_q),
    .wr_data_i (wdata_q)
  );

  // Read FSM: capture address, count down the latency, then hold the response until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      lat_cnt_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: if (arvalid) begin
          ar_addr_q <= araddr;
          lat_cnt_q <= LAT_LOAD;
          r_state_q <= R_WAIT;
        end
        R_WAIT: if (lat_cnt_q == '0) begin
          rdata_q   <= ar_err ? '0 : ram_rd_data;
          rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
          r_state_q <= R_RESP;
        end else begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
        end
        R_RESP: if (rready) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: collect AW and W independently, commit for one cycle, then hold the response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= awaddr;
            aw_got_q  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_got_q <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_q <= W_MEM;
        end
        W_MEM: begin
          bresp_q   <= aw_err ? RESP_SLVERR : RESP_OKAY;
          aw_got_q  <= 1'b0;
          w_got_q   <= 1'b0;
          w_state_q <= W_RESP;
        end
        W_RESP: if (bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

endmodule
